jt10_adpcm_rom_bridge: RTL and testbench

//  Sits directly downstream of the YM2610 wrapper's ADPCM ROM pins. It turns the ADPCM-A
//  (bank+addr, roe_n) and ADPCM-B (addr, roe_n) byte fetches into reads on one shared
//  16-bit memory port (SDRAM controller). Each channel has a one-word cache, and an

---
 rtl/jt10_adpcm_rom_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_jt10_adpcm_rom_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcm_rom_bridge.sv
// Bridges the YM2610 ADPCM-A/B ROM byte fetches onto one shared 16-bit memory read port,
// with a one-word cache per channel and a round-robin arbiter serialising the misses.
module jt10_adpcm_rom_bridge #(
    parameter int          MEM_AW = 24,
    parameter logic [24:0] A_BASE = 25'h0000000,
    parameter logic [24:0] B_BASE = 25'h1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [19:0]       adpcma_addr,
    input  logic [4:0]        adpcma_bank,
    input  logic              adpcma_roe_n,
    output logic [7:0]        adpcma_data,
    input  logic [23:0]       adpcmb_addr,
    input  logic              adpcmb_roe_n,
    output logic [7:0]        adpcmb_data,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [15:0]       mem_rdata,
    output logic              busy
);
    localparam int CH_A = 0;
    localparam int CH_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic bsel);
        logic [7:0] b;
        if (bsel) begin
            b = word[15:8];
        end else begin
            b = word[7:0];
        end
        return b;
    endfunction

    // Address mapping (channel index 0 = ADPCM-A, 1 = ADPCM-B)
    logic [24:0]              a_byte_s;
    logic [24:0]              b_byte_s;
    logic [23:0]              a_wfull_s;
    logic [23:0]              b_wfull_s;
    logic [1:0][MEM_AW-1:0]   waddr_s;
    logic [1:0]               bsel_s;
    logic [1:0]               roe_n_s;

    assign a_byte_s        = A_BASE + {adpcma_bank, adpcma_addr};
    assign b_byte_s        = B_BASE + {1'b0, adpcmb_addr};
    assign a_wfull_s       = a_byte_s[24:1];
    assign b_wfull_s       = b_byte_s[24:1];
    assign waddr_s[CH_A]   = a_wfull_s[MEM_AW-1:0];
    assign waddr_s[CH_B]   = b_wfull_s[MEM_AW-1:0];
    assign bsel_s          = {b_byte_s[0], a_byte_s[0]};
    assign roe_n_s         = {adpcmb_roe_n, adpcma_roe_n};

    // Arbiter state
    state_t              state_r, state_n;
    logic                owner_r, owner_n;
    logic                rr_r, rr_n;
    logic                mem_req_r, mem_req_n;
    logic [MEM_AW-1:0]   mem_addr_r, mem_addr_n;
    logic                busy_r;
    logic                grant_s, pick_s, done_s;

    // Per-channel state
    logic [1:0]              prev_roe_r, prev_roe_n;
    logic [1:0][MEM_AW-1:0]  last_waddr_r, last_waddr_n;
    logic [1:0]              pend_r, pend_n;
    logic [1:0]              stale_r, stale_n;
    logic [1:0][MEM_AW-1:0]  req_waddr_r, req_waddr_n;
    logic [1:0]              req_bsel_r, req_bsel_n;
    logic [1:0][15:0]        cache_word_r, cache_word_n;
    logic [1:0][MEM_AW-1:0]  cache_tag_r, cache_tag_n;
    logic [1:0]              cache_vld_r, cache_vld_n;
    logic [1:0][7:0]         dout_r, dout_n;
    logic [1:0]              trig_s, hit_s, fly_s, cmp_s;

    // Arbiter next state: grant a pending channel, hold the request until ack, await data
    always_comb begin
        state_n    = state_r;
        owner_n    = owner_r;
        rr_n       = rr_r;
        mem_req_n  = mem_req_r;
        mem_addr_n = mem_addr_r;
        grant_s    = 1'b0;
        pick_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|pend_r) begin
                    grant_s = 1'b1;
                    // rr_r only advances on contested grants so A wins the first tie
                    if (&pend_r) begin
                        pick_s = rr_r;
                        rr_n   = ~rr_r;
                    end else begin
                        pick_s = pend_r[CH_B];
                    end
                    owner_n    = pick_s;
                    mem_addr_n = req_waddr_r[pick_s];
                    mem_req_n  = 1'b1;
                    state_n    = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    if (mem_valid) begin
                        done_s  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    done_s  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // Channel next state: trigger detection, cache hit service, miss capture, completion
    always_comb begin
        prev_roe_n   = prev_roe_r;
        last_waddr_n = last_waddr_r;
        pend_n       = pend_r;
        stale_n      = stale_r;
        req_waddr_n  = req_waddr_r;
        req_bsel_n   = req_bsel_r;
        cache_word_n = cache_word_r;
        cache_tag_n  = cache_tag_r;
        cache_vld_n  = cache_vld_r;
        dout_n       = dout_r;
        trig_s       = 2'b00;
        hit_s        = 2'b00;
        fly_s        = 2'b00;
        cmp_s        = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            trig_s[ch] = !roe_n_s[ch] &&
                         (prev_roe_r[ch] || (waddr_s[ch] != last_waddr_r[ch]));
            hit_s[ch]  = trig_s[ch] && !pend_r[ch] && cache_vld_r[ch] &&
                         (waddr_s[ch] == cache_tag_r[ch]);
            // The grant cycle counts as in flight: mem_addr is already loaded from the old capture
            fly_s[ch]  = ((state_r != ST_IDLE) && (owner_r == 1'(ch))) ||
                         (grant_s && (pick_s == 1'(ch)));
            cmp_s[ch]  = done_s && (owner_r == 1'(ch));
            prev_roe_n[ch] = roe_n_s[ch];

            if (cmp_s[ch]) begin
                cache_word_n[ch] = mem_rdata;
                cache_tag_n[ch]  = mem_addr_r;
                cache_vld_n[ch]  = 1'b1;
                stale_n[ch]      = 1'b0;
                if (!stale_r[ch] && !trig_s[ch]) begin
                    dout_n[ch] = pick_byte(mem_rdata, req_bsel_r[ch]);
                    pend_n[ch] = 1'b0;
                end else begin
                    pend_n[ch] = 1'b1;
                end
            end else begin
                cache_vld_n[ch] = cache_vld_r[ch];
            end

            if (trig_s[ch]) begin
                last_waddr_n[ch] = waddr_s[ch];
                if (hit_s[ch]) begin
                    dout_n[ch] = pick_byte(cache_word_r[ch], bsel_s[ch]);
                end else begin
                    req_waddr_n[ch] = waddr_s[ch];
                    req_bsel_n[ch]  = bsel_s[ch];
                    pend_n[ch]      = 1'b1;
                    if (fly_s[ch] && !cmp_s[ch]) begin
                        stale_n[ch] = 1'b1;
                    end else begin
                        stale_n[ch] = stale_n[ch];
                    end
                end
            end else begin
                last_waddr_n[ch] = last_waddr_n[ch];
            end
        end
    end

    // Arbiter registers and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= 1'b0;
            rr_r       <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {MEM_AW{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            owner_r    <= owner_n;
            rr_r       <= rr_n;
            mem_req_r  <= mem_req_n;
            mem_addr_r <= mem_addr_n;
            busy_r     <= (state_n != ST_IDLE) || (|pend_n);
        end
    end

    // Channel registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_roe_r   <= 2'b11;
            last_waddr_r <= '0;
            pend_r       <= 2'b00;
            stale_r      <= 2'b00;
            req_waddr_r  <= '0;
            req_bsel_r   <= 2'b00;
            cache_word_r <= '0;
            cache_tag_r  <= '0;
            cache_vld_r  <= 2'b00;
            dout_r       <= '0;
        end else begin
            prev_roe_r   <= prev_roe_n;
            last_waddr_r <= last_waddr_n;
            pend_r       <= pend_n;
            stale_r      <= stale_n;
            req_waddr_r  <= req_waddr_n;
            req_bsel_r   <= req_bsel_n;
            cache_word_r <= cache_word_n;
            cache_tag_r  <= cache_tag_n;
            cache_vld_r  <= cache_vld_n;
            dout_r       <= dout_n;
        end
    end

    assign adpcma_data = dout_r[CH_A];
    assign adpcmb_data = dout_r[CH_B];
    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_jt10_adpcm_rom_bridge.sv
// Directed bench for jt10_adpcm_rom_bridge: hand-computed addresses and bytes per scenario.
`timescale 1ns/1ps
module tb_jt10_adpcm_rom_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] adpcma_addr;
    logic [4:0]  adpcma_bank;
    logic        adpcma_roe_n;
    logic [7:0]  adpcma_data;
    logic [23:0] adpcmb_addr;
    logic        adpcmb_roe_n;
    logic [7:0]  adpcmb_data;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    jt10_adpcm_rom_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adpcma_addr  (adpcma_addr),
        .adpcma_bank  (adpcma_bank),
        .adpcma_roe_n (adpcma_roe_n),
        .adpcma_data  (adpcma_data),
        .adpcmb_addr  (adpcmb_addr),
        .adpcmb_roe_n (adpcmb_roe_n),
        .adpcmb_data  (adpcmb_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for mem_req, acks it, then returns mem_rdata val_dly clk after the ack
    task automatic mem_serve(input int val_dly, input logic [15:0] word,
                             output logic [23:0] addr_seen, output bit seen);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        seen      = (mem_req === 1'b1);
        addr_seen = mem_addr;
        if (seen) begin
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            repeat (val_dly - 1) step();
            mem_valid = 1'b1;
            mem_rdata = word;
            step();
            mem_valid = 1'b0;
        end
    endtask

    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        seen = (mem_req === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; adpcma_addr = 20'h0; adpcma_bank = 5'h0; adpcma_roe_n = 1'b1;
        adpcmb_addr = 24'h0; adpcmb_roe_n = 1'b1;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = 16'h0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (adpcma_data !== 8'h00) begin failures++; $display("FAIL reset_adata: got %h expected 00", adpcma_data); end
        checks++; if (adpcmb_data !== 8'h00) begin failures++; $display("FAIL reset_bdata: got %h expected 00", adpcmb_data); end
        checks++; if (mem_addr !== 24'h0) begin failures++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_miss();
        logic [23:0] a; bit seen;
        adpcma_bank = 5'd0; adpcma_addr = 20'h00003; adpcma_roe_n = 1'b0;
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL miss_req_early: got %b expected 0", mem_req); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL miss_busy: got %b expected 1", busy); end
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL miss_req_rise: got %b expected 1", mem_req); end
        mem_serve(3, 16'hBEEF, a, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL miss_seen: got %b expected 1", seen); end
        checks++; if (a !== 24'h000001) begin failures++; $display("FAIL miss_addr: got %h expected 000001", a); end
        checks++; if (adpcma_data !== 8'hBE) begin failures++; $display("FAIL miss_data: got %h expected be", adpcma_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL miss_idle: got %b expected 0", busy); end
    endtask

    task automatic test_hit();
        adpcma_roe_n = 1'b1;
        step();
        adpcma_addr = 20'h00002; adpcma_roe_n = 1'b0;
        step();
        checks++; if (adpcma_data !== 8'hEF) begin failures++; $display("FAIL hit_data: got %h expected ef", adpcma_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hit_busy: got %b expected 0", busy); end
        step(); step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_noreq: got %b expected 0", mem_req); end
    endtask

    task automatic test_arbitration();
        logic [23:0] a; bit seen;
        adpcma_addr = 20'h00040; adpcmb_addr = 24'h000020; adpcmb_roe_n = 1'b0;
        mem_serve(1, 16'h1234, a, seen);
        checks++; if (a !== 24'h000020 || !seen) begin failures++; $display("FAIL arb1_first: got %h expected 000020", a); end
        checks++; if (adpcma_data !== 8'h34) begin failures++; $display("FAIL arb1_adata: got %h expected 34", adpcma_data); end
        mem_serve(1, 16'h5678, a, seen);
        checks++; if (a !== 24'h800010 || !seen) begin failures++; $display("FAIL arb1_second: got %h expected 800010", a); end
        checks++; if (adpcmb_data !== 8'h78) begin failures++; $display("FAIL arb1_bdata: got %h expected 78", adpcmb_data); end
        step();
        adpcma_addr = 20'h00050; adpcmb_addr = 24'h000010;
        mem_serve(1, 16'hCAFE, a, seen);
        checks++; if (a !== 24'h800008 || !seen) begin failures++; $display("FAIL arb2_first: got %h expected 800008", a); end
        checks++; if (adpcmb_data !== 8'hFE) begin failures++; $display("FAIL arb2_bdata: got %h expected fe", adpcmb_data); end
        mem_serve(1, 16'h0102, a, seen);
        checks++; if (a !== 24'h000028 || !seen) begin failures++; $display("FAIL arb2_second: got %h expected 000028", a); end
        checks++; if (adpcma_data !== 8'h02) begin failures++; $display("FAIL arb2_adata: got %h expected 02", adpcma_data); end
    endtask

    task automatic test_stale();
        logic [23:0] a; bit seen;
        adpcma_addr = 20'h00010;
        wait_req(seen);
        checks++; if (mem_addr !== 24'h000008 || !seen) begin failures++; $display("FAIL stale_addr1: got %h expected 000008", mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        adpcmb_roe_n = 1'b1;
        step();
        adpcma_addr = 20'h00020; adpcmb_roe_n = 1'b0; adpcmb_addr = 24'h000011;
        step();
        checks++; if (adpcmb_data !== 8'hCA) begin failures++; $display("FAIL busy_hit_bdata: got %h expected ca", adpcmb_data); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL busy_hit_req: got %b expected 0", mem_req); end
        mem_valid = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_valid = 1'b0;
        checks++; if (adpcma_data !== 8'h02) begin failures++; $display("FAIL stale_discard: got %h expected 02", adpcma_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stale_busy: got %b expected 1", busy); end
        mem_serve(2, 16'h4321, a, seen);
        checks++; if (a !== 24'h000010 || !seen) begin failures++; $display("FAIL stale_addr2: got %h expected 000010", a); end
        checks++; if (adpcma_data !== 8'h21) begin failures++; $display("FAIL stale_data: got %h expected 21", adpcma_data); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        adpcmb_addr = 24'h000030;
        wait_req(seen);
        checks++; if (mem_addr !== 24'h800018 || !seen) begin failures++; $display("FAIL rstmid_addr: got %h expected 800018", mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %b expected 0", mem_req); end
        checks++; if (adpcma_data !== 8'h00) begin failures++; $display("FAIL rstmid_adata: got %h expected 00", adpcma_data); end
        checks++; if (adpcmb_data !== 8'h00) begin failures++; $display("FAIL rstmid_bdata: got %h expected 00", adpcmb_data); end
        adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        mem_valid = 1'b1; mem_rdata = 16'hFFFF;
        step();
        mem_valid = 1'b0;
        step();
        checks++; if (adpcma_data !== 8'h00 || adpcmb_data !== 8'h00) begin failures++; $display("FAIL late_valid_data: got %h/%h expected 00/00", adpcma_data, adpcmb_data); end
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL late_valid_idle: got busy=%b req=%b expected 0/0", busy, mem_req); end
    endtask

    task automatic test_ack_holdoff();
        logic [23:0] a; bit seen;
        adpcma_bank = 5'd1; adpcma_addr = 20'h00100; adpcma_roe_n = 1'b0;
        wait_req(seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL hold_seen: got %b expected 1", seen); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL hold_req[%0d]: got %b expected 1", i, mem_req); end
            checks++; if (mem_addr !== 24'h080080) begin failures++; $display("FAIL hold_addr[%0d]: got %h expected 080080", i, mem_addr); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy[%0d]: got %b expected 1", i, busy); end
            step();
        end
        mem_serve(2, 16'h9988, a, seen);
        checks++; if (a !== 24'h080080 || !seen) begin failures++; $display("FAIL hold_final_addr: got %h expected 080080", a); end
        checks++; if (adpcma_data !== 8'h88) begin failures++; $display("FAIL hold_data: got %h expected 88", adpcma_data); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_arbitration();
        test_stale();
        test_reset_mid();
        test_ack_holdoff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
